// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and baud divider helper.
`timescale 1ns/1ps
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int unsigned DATA_BITS = 8;

   // Integer divide; any remainder shows up as baud error on the line.
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx, samples each bit at mid-bit and strobes out
// correctly framed bytes (data_valid) or bad stop bits (frame_error).
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       data_valid,
   output logic [7:0] data,
   output logic       frame_error
);

   localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W = $clog2(CPB) + 1;
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   state_t               state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 armed;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // armed drops after a frame error so a held-low line (break) reports only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         armed       <= 1'b1;
         data        <= 8'h00;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         unique case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (!armed) begin
                  if (rx_s) armed <= 1'b1;
               end else if (!rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (clk_cnt == CNT_HALF) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (clk_cnt == CNT_FULL) begin
                  clk_cnt            <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx == IDX_LAST) state <= STOP;
                  else                     bit_idx <= bit_idx + IDX_W'(1);
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (clk_cnt == CNT_FULL) begin
                  clk_cnt <= '0;
                  state   <= IDLE;
                  if (rx_s) begin
                     data       <= shift_reg;
                     data_valid <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                     armed       <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomized 8N1 frames checked against a byte-level
// scoreboard, plus per-cycle pulse-width, data-stability and X checks.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       data_valid;
   logic [7:0] data;
   logic       frame_error;

   int unsigned n_tests;
   int unsigned n_fail;

   logic [7:0] rx_q[$];
   time        vt_q[$];
   logic [7:0] exp_q[$];
   int unsigned fe_cnt;
   int unsigned exp_fe;
   logic [7:0] exp_data;
   logic       prev_valid;
   logic [7:0] prev_data;

   uart_rx #(.CLK_FREQ(100_000_000), .BAUD(1_000_000)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .data_valid  (data_valid),
      .data        (data),
      .frame_error (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Per-cycle monitor: records pulses and checks width, exclusivity, stability, X.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_data  = data;
      end else begin
         n_tests++;
         assert (!$isunknown({data_valid, frame_error, data})) else begin
            n_fail++;
            $error("FAIL xcheck got %b/%b/%h exp known", data_valid, frame_error, data);
         end
         if (data_valid) begin
            n_tests += 2;
            assert (prev_valid === 1'b0) else begin
               n_fail++;
               $error("FAIL pulse_width got 2+ cycles exp 1");
            end
            assert (frame_error === 1'b0) else begin
               n_fail++;
               $error("FAIL exclusive got fe=1 with valid exp fe=0");
            end
            rx_q.push_back(data);
            vt_q.push_back($time);
         end else begin
            n_tests++;
            assert (data === prev_data) else begin
               n_fail++;
               $error("FAIL data_stable got %h exp %h", data, prev_data);
            end
         end
         if (frame_error) fe_cnt++;
         prev_valid = data_valid;
         prev_data  = data;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int unsigned bit_ns);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop_bit;
      #(bit_ns);
      rx = 1'b1;
   endtask

   // Model: good frame -> byte pushed and becomes data; bad stop -> error count only.
   task automatic model_frame(input logic [7:0] b, input logic stop_bit);
      if (stop_bit) begin
         exp_q.push_back(b);
         exp_data = b;
      end else begin
         exp_fe++;
      end
   endtask

   task automatic check_scoreboard(input string tag);
      logic [7:0] got;
      logic [7:0] want;
      n_tests++;
      assert (rx_q.size() === exp_q.size()) else begin
         n_fail++;
         $error("FAIL %s pulse_count got %0d exp %0d", tag, rx_q.size(), exp_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         got  = rx_q.pop_front();
         want = exp_q.pop_front();
         n_tests++;
         assert (got === want) else begin
            n_fail++;
            $error("FAIL %s byte got %h exp %h", tag, got, want);
         end
      end
      rx_q.delete();
      exp_q.delete();
      vt_q.delete();
      n_tests += 2;
      assert (fe_cnt === exp_fe) else begin
         n_fail++;
         $error("FAIL %s frame_errors got %0d exp %0d", tag, fe_cnt, exp_fe);
      end
      assert (data === exp_data) else begin
         n_fail++;
         $error("FAIL %s data got %h exp %h", tag, data, exp_data);
      end
   endtask

   initial begin
      time         t_start;
      longint      lat;
      longint      gap;
      logic [7:0]  b;
      logic        sb;
      int unsigned bns;

      n_tests  = 0;
      n_fail   = 0;
      fe_cnt   = 0;
      exp_fe   = 0;
      exp_data = 8'h00;
      rx  = 1'b1;
      rst = 1'b1;
      #20;
      n_tests++;
      assert ({data_valid, frame_error, data} === 10'h000) else begin
         n_fail++;
         $error("FAIL reset_state got %b/%b/%h exp 0/0/00", data_valid, frame_error, data);
      end
      #30;
      rst = 1'b0;
      #2000;

      // Single frame "T" with latency check from falling edge to valid.
      t_start = $time;
      send_byte(8'h54, 1'b1, 1000);
      model_frame(8'h54, 1'b1);
      #2000;
      n_tests++;
      if (vt_q.size() > 0) lat = longint'((vt_q[0] - t_start) / 10);
      else                 lat = -1;
      assert (lat >= 950 && lat <= 954) else begin
         n_fail++;
         $error("FAIL latency got %0d clks exp 952 +-2", lat);
      end
      check_scoreboard("frame_T");

      // Back-to-back ":" then "1" with no idle gap.
      send_byte(8'h3A, 1'b1, 1000);
      send_byte(8'h31, 1'b1, 1000);
      model_frame(8'h3A, 1'b1);
      model_frame(8'h31, 1'b1);
      #2000;
      n_tests++;
      if (vt_q.size() == 2) gap = longint'((vt_q[1] - vt_q[0]) / 10);
      else                  gap = -1;
      assert (gap >= 998 && gap <= 1002) else begin
         n_fail++;
         $error("FAIL b2b_spacing got %0d clks exp 1000", gap);
      end
      check_scoreboard("back_to_back");

      // Glitch shorter than half a bit, then a valid frame.
      rx = 1'b0;
      #300;
      rx = 1'b1;
      #2000;
      check_scoreboard("glitch");
      send_byte(8'hA5, 1'b1, 1000);
      model_frame(8'hA5, 1'b1);
      #2000;
      check_scoreboard("after_glitch");

      // Bad stop bit, line raised, then a good frame.
      send_byte(8'h55, 1'b0, 1000);
      model_frame(8'h55, 1'b0);
      #2000;
      check_scoreboard("bad_stop");
      send_byte(8'h0F, 1'b1, 1000);
      model_frame(8'h0F, 1'b1);
      #2000;
      check_scoreboard("after_bad_stop");

      // Break: line held low for many bit times reports one frame error only.
      rx = 1'b0;
      #25000;
      rx = 1'b1;
      exp_fe++;
      #3000;
      check_scoreboard("break");

      // Reset during bit 4 of 8'hFF, then a good frame.
      fork
         send_byte(8'hFF, 1'b1, 1000);
         begin
            #5500;
            rst = 1'b1;
            #20;
            n_tests++;
            assert ({data_valid, frame_error, data} === 10'h000) else begin
               n_fail++;
               $error("FAIL mid_reset got %b/%b/%h exp 0/0/00", data_valid, frame_error, data);
            end
            #30;
            rst = 1'b0;
         end
      join
      exp_data = 8'h00;
      #2000;
      check_scoreboard("reset_mid_frame");
      send_byte(8'h81, 1'b1, 1000);
      model_frame(8'h81, 1'b1);
      #2000;
      check_scoreboard("after_reset");

      // Randomized frames with small baud skew, random gaps and occasional bad stops.
      for (int k = 0; k < 10; k++) begin
         b   = 8'($urandom_range(0, 255));
         sb  = ($urandom_range(0, 4) != 0);
         bns = 980 + $urandom_range(0, 40);
         send_byte(b, sb, bns);
         model_frame(b, sb);
         if (!sb) #(1000 + $urandom_range(0, 1000));
         else     #($urandom_range(0, 2000));
      end
      #2000;
      check_scoreboard("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
